// File: rtl/rvfi_trace_pkg.sv
// Shared types and helpers for the RVFI retirement tracer.
//   - rvfi_rec_t     : packed payload of one retirement record, all fields
//                      except rvfi_valid, rvfi_order and rvfi_intr.
//   - tracer_state_e : tracer FSM states.
//   - is_illegal()   : instruction-word legality test.
// The record widths are fixed at REC_XLEN/REC_ILEN.
// The tracer's XLEN/ILEN parameters must match them.
package rvfi_trace_pkg;

    localparam int REC_XLEN = 32;
    localparam int REC_ILEN = 32;

    // Every 32-bit (non-compressed) encoding has both low opcode bits set.
    localparam logic [1:0] OPC_LOW_BITS = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } tracer_state_e;

    typedef struct packed {
        logic [REC_ILEN-1:0]   insn;
        logic                  trap;
        logic                  halt;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic [4:0]            rd_addr;
        logic [REC_XLEN-1:0]   rs1_rdata;
        logic [REC_XLEN-1:0]   rs2_rdata;
        logic [REC_XLEN-1:0]   rd_wdata;
        logic [REC_XLEN-1:0]   pc_rdata;
        logic [REC_XLEN-1:0]   pc_wdata;
        logic [REC_XLEN-1:0]   mem_addr;
        logic [REC_XLEN-1:0]   mem_rdata;
        logic [REC_XLEN-1:0]   mem_wdata;
        logic [REC_XLEN/8-1:0] mem_rmask;
        logic [REC_XLEN/8-1:0] mem_wmask;
    } rvfi_rec_t;

    function automatic logic is_illegal(input logic [REC_ILEN-1:0] insn);
        return (insn == '0) || (insn[1:0] != OPC_LOW_BITS);
    endfunction

endpackage

// File: rtl/rvfi_rec_sanitise.sv
// Combinational clean-up of one retirement record.
// The result satisfies the RVFI consistency checks by construction.
//   rec_i : raw record; rec_i.trap carries the core's trap flag.
//   rec_o : sanitised record.
// Rules, in priority order:
//   1. An illegal instruction traps, and its rd and memory masks are cleared.
//   2. Otherwise a core trap clears rd and the write mask.
//   3. Writes to x0 always report zero write data.
module rvfi_rec_sanitise
    import rvfi_trace_pkg::*;
(
    input  rvfi_rec_t rec_i,
    output rvfi_rec_t rec_o
);

    // NOTE: rec_o gets a full default before any conditional update, so no
    // path through the block leaves a field unassigned (no latch inferred).
    always_comb begin
        rec_o = rec_i;
        if (is_illegal(rec_i.insn)) begin
            rec_o.trap      = 1'b1;
            rec_o.rd_addr   = '0;
            rec_o.rd_wdata  = '0;
            rec_o.mem_wmask = '0;
            rec_o.mem_rmask = '0;
        end else if (rec_i.trap) begin
            rec_o.rd_addr   = '0;
            rec_o.rd_wdata  = '0;
            rec_o.mem_wmask = '0;
        end
        // Applied last so that it also covers an rd cleared above.
        if (rec_o.rd_addr == 5'd0) begin
            rec_o.rd_wdata = '0;
        end
    end

endmodule

// File: rtl/rvfi_retire_tracer.sv
// Producer end of a single-channel (NRET=1) RVFI trace port.
// Inputs : clock, synchronous active-high reset, and the writeback-stage
//          retirement record ret_* with its ret_valid/ret_ready handshake.
// Outputs: the registered rvfi_* trace. rvfi_valid pulses for one cycle
//          after each accept; the payload holds its value in between.
// An accepted record with ret_halt set moves the tracer to HALTED.
// In HALTED the tracer accepts nothing more until reset.
module rvfi_retire_tracer
    import rvfi_trace_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ILEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ret_valid,
    output logic                ret_ready,
    input  logic [ILEN-1:0]     ret_insn,
    input  logic [XLEN-1:0]     ret_pc,
    input  logic [XLEN-1:0]     ret_next_pc,
    input  logic [4:0]          ret_rs1_addr,
    input  logic [4:0]          ret_rs2_addr,
    input  logic [XLEN-1:0]     ret_rs1_rdata,
    input  logic [XLEN-1:0]     ret_rs2_rdata,
    input  logic [4:0]          ret_rd_addr,
    input  logic [XLEN-1:0]     ret_rd_wdata,
    input  logic [XLEN-1:0]     ret_mem_addr,
    input  logic [XLEN-1:0]     ret_mem_rdata,
    input  logic [XLEN-1:0]     ret_mem_wdata,
    input  logic [XLEN/8-1:0]   ret_mem_rmask,
    input  logic [XLEN/8-1:0]   ret_mem_wmask,
    input  logic                ret_trap,
    input  logic                ret_halt,

    output logic                rvfi_valid,
    output logic [ORDER_W-1:0]  rvfi_order,
    output logic [ILEN-1:0]     rvfi_insn,
    output logic                rvfi_trap,
    output logic                rvfi_halt,
    output logic                rvfi_intr,
    output logic [4:0]          rvfi_rs1_addr,
    output logic [4:0]          rvfi_rs2_addr,
    output logic [4:0]          rvfi_rd_addr,
    output logic [XLEN-1:0]     rvfi_rs1_rdata,
    output logic [XLEN-1:0]     rvfi_rs2_rdata,
    output logic [XLEN-1:0]     rvfi_rd_wdata,
    output logic [XLEN-1:0]     rvfi_pc_rdata,
    output logic [XLEN-1:0]     rvfi_pc_wdata,
    output logic [XLEN-1:0]     rvfi_mem_addr,
    output logic [XLEN-1:0]     rvfi_mem_rdata,
    output logic [XLEN-1:0]     rvfi_mem_wdata,
    output logic [XLEN/8-1:0]   rvfi_mem_rmask,
    output logic [XLEN/8-1:0]   rvfi_mem_wmask
);

    tracer_state_e      state_q, state_d;
    logic [ORDER_W-1:0] order_cnt_q, order_cnt_d;
    logic               intr_pending_q, intr_pending_d;
    logic               rvfi_valid_q, rvfi_valid_d;
    logic [ORDER_W-1:0] rvfi_order_q, rvfi_order_d;
    logic               rvfi_intr_q, rvfi_intr_d;
    rvfi_rec_t          rvfi_rec_q, rvfi_rec_d;

    rvfi_rec_t raw_rec;
    rvfi_rec_t clean_rec;
    logic      accept;

    always_comb begin
        raw_rec           = '0;
        raw_rec.insn      = ret_insn;
        raw_rec.trap      = ret_trap;
        raw_rec.halt      = ret_halt;
        raw_rec.rs1_addr  = ret_rs1_addr;
        raw_rec.rs2_addr  = ret_rs2_addr;
        raw_rec.rd_addr   = ret_rd_addr;
        raw_rec.rs1_rdata = ret_rs1_rdata;
        raw_rec.rs2_rdata = ret_rs2_rdata;
        raw_rec.rd_wdata  = ret_rd_wdata;
        raw_rec.pc_rdata  = ret_pc;
        raw_rec.pc_wdata  = ret_next_pc;
        raw_rec.mem_addr  = ret_mem_addr;
        raw_rec.mem_rdata = ret_mem_rdata;
        raw_rec.mem_wdata = ret_mem_wdata;
        raw_rec.mem_rmask = ret_mem_rmask;
        raw_rec.mem_wmask = ret_mem_wmask;
    end

    rvfi_rec_sanitise u_sanitise (
        .rec_i (raw_rec),
        .rec_o (clean_rec)
    );

    assign ret_ready = (state_q == RUN);
    assign accept    = ret_valid && ret_ready;

    always_comb begin
        state_d        = state_q;
        order_cnt_d    = order_cnt_q;
        intr_pending_d = intr_pending_q;
        rvfi_order_d   = rvfi_order_q;
        rvfi_intr_d    = rvfi_intr_q;
        rvfi_rec_d     = rvfi_rec_q;
        rvfi_valid_d   = accept;
        if (accept) begin
            rvfi_rec_d   = clean_rec;
            rvfi_order_d = order_cnt_q;
            order_cnt_d  = order_cnt_q + ORDER_W'(1);
            // The record after any trap is the handler entry. A trap on
            // that record re-arms the flag for the record after it.
            rvfi_intr_d    = intr_pending_q;
            intr_pending_d = clean_rec.trap;
            if (ret_halt) begin
                state_d = HALTED;
            end
        end
    end

    // NOTE: the payload register is reset along with the control flops
    // because the trace outputs must read zero straight after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            order_cnt_q    <= '0;
            intr_pending_q <= 1'b0;
            rvfi_valid_q   <= 1'b0;
            rvfi_order_q   <= '0;
            rvfi_intr_q    <= 1'b0;
            rvfi_rec_q     <= '0;
        end else begin
            state_q        <= state_d;
            order_cnt_q    <= order_cnt_d;
            intr_pending_q <= intr_pending_d;
            rvfi_valid_q   <= rvfi_valid_d;
            rvfi_order_q   <= rvfi_order_d;
            rvfi_intr_q    <= rvfi_intr_d;
            rvfi_rec_q     <= rvfi_rec_d;
        end
    end

    assign rvfi_valid     = rvfi_valid_q;
    assign rvfi_order     = rvfi_order_q;
    assign rvfi_intr      = rvfi_intr_q;
    assign rvfi_insn      = rvfi_rec_q.insn;
    assign rvfi_trap      = rvfi_rec_q.trap;
    assign rvfi_halt      = rvfi_rec_q.halt;
    assign rvfi_rs1_addr  = rvfi_rec_q.rs1_addr;
    assign rvfi_rs2_addr  = rvfi_rec_q.rs2_addr;
    assign rvfi_rd_addr   = rvfi_rec_q.rd_addr;
    assign rvfi_rs1_rdata = rvfi_rec_q.rs1_rdata;
    assign rvfi_rs2_rdata = rvfi_rec_q.rs2_rdata;
    assign rvfi_rd_wdata  = rvfi_rec_q.rd_wdata;
    assign rvfi_pc_rdata  = rvfi_rec_q.pc_rdata;
    assign rvfi_pc_wdata  = rvfi_rec_q.pc_wdata;
    assign rvfi_mem_addr  = rvfi_rec_q.mem_addr;
    assign rvfi_mem_rdata = rvfi_rec_q.mem_rdata;
    assign rvfi_mem_wdata = rvfi_rec_q.mem_wdata;
    assign rvfi_mem_rmask = rvfi_rec_q.mem_rmask;
    assign rvfi_mem_wmask = rvfi_rec_q.mem_wmask;

endmodule

// File: tb/tb_rvfi_retire_tracer.sv
// Directed testbench for rvfi_retire_tracer.
// A default-width instance (dut) exercises the main behaviour.
// A 4-bit order-counter instance (dut4) shares the stimulus and exercises
// wrap-around of rvfi_order.
module tb_rvfi_retire_tracer;

    localparam logic [31:0] ADD = 32'h0020_81B3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ret_valid;
    logic [31:0] ret_insn, ret_pc, ret_next_pc;
    logic [4:0]  ret_rs1_addr, ret_rs2_addr, ret_rd_addr;
    logic [31:0] ret_rs1_rdata, ret_rs2_rdata, ret_rd_wdata;
    logic [31:0] ret_mem_addr, ret_mem_rdata, ret_mem_wdata;
    logic [3:0]  ret_mem_rmask, ret_mem_wmask;
    logic        ret_trap, ret_halt;

    logic        ret_ready, rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    logic        d4_ret_ready, d4_valid, d4_trap, d4_halt, d4_intr;
    logic [3:0]  d4_order;
    logic [31:0] d4_insn, d4_rs1_rdata, d4_rs2_rdata, d4_rd_wdata;
    logic [31:0] d4_pc_rdata, d4_pc_wdata, d4_mem_addr, d4_mem_rdata, d4_mem_wdata;
    logic [4:0]  d4_rs1_addr, d4_rs2_addr, d4_rd_addr;
    logic [3:0]  d4_mem_rmask, d4_mem_wmask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    rvfi_retire_tracer dut (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_insn(ret_insn),
        .ret_pc(ret_pc), .ret_next_pc(ret_next_pc),
        .ret_rs1_addr(ret_rs1_addr), .ret_rs2_addr(ret_rs2_addr),
        .ret_rs1_rdata(ret_rs1_rdata), .ret_rs2_rdata(ret_rs2_rdata),
        .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
        .ret_mem_addr(ret_mem_addr), .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata),
        .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .ret_trap(ret_trap), .ret_halt(ret_halt),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask)
    );

    rvfi_retire_tracer #(.ORDER_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_ready(d4_ret_ready), .ret_insn(ret_insn),
        .ret_pc(ret_pc), .ret_next_pc(ret_next_pc),
        .ret_rs1_addr(ret_rs1_addr), .ret_rs2_addr(ret_rs2_addr),
        .ret_rs1_rdata(ret_rs1_rdata), .ret_rs2_rdata(ret_rs2_rdata),
        .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
        .ret_mem_addr(ret_mem_addr), .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata),
        .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .ret_trap(ret_trap), .ret_halt(ret_halt),
        .rvfi_valid(d4_valid), .rvfi_order(d4_order), .rvfi_insn(d4_insn),
        .rvfi_trap(d4_trap), .rvfi_halt(d4_halt), .rvfi_intr(d4_intr),
        .rvfi_rs1_addr(d4_rs1_addr), .rvfi_rs2_addr(d4_rs2_addr), .rvfi_rd_addr(d4_rd_addr),
        .rvfi_rs1_rdata(d4_rs1_rdata), .rvfi_rs2_rdata(d4_rs2_rdata), .rvfi_rd_wdata(d4_rd_wdata),
        .rvfi_pc_rdata(d4_pc_rdata), .rvfi_pc_wdata(d4_pc_wdata),
        .rvfi_mem_addr(d4_mem_addr), .rvfi_mem_rdata(d4_mem_rdata), .rvfi_mem_wdata(d4_mem_wdata),
        .rvfi_mem_rmask(d4_mem_rmask), .rvfi_mem_wmask(d4_mem_wmask)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] insn, input logic [4:0] rd,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic trap, input logic halt);
        ret_valid     = 1'b1;
        ret_insn      = insn;
        ret_rd_addr   = rd;
        ret_rd_wdata  = wdata;
        ret_mem_wmask = wmask;
        ret_mem_rmask = 4'hF;
        ret_trap      = trap;
        ret_halt      = halt;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ret_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        ret_pc        = 32'h0000_0100;
        ret_next_pc   = 32'h0000_0104;
        ret_rs1_addr  = 5'd1;
        ret_rs2_addr  = 5'd2;
        ret_rs1_rdata = 32'd2;
        ret_rs2_rdata = 32'd3;
        ret_mem_addr  = 32'h0000_2000;
        ret_mem_rdata = 32'hCAFE_0000;
        ret_mem_wdata = 32'h0000_BEEF;
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        do_reset();

        // Reset state.
        check("rst_valid", rvfi_valid, 1'b0);
        check("rst_order", rvfi_order, 64'd0);
        check("rst_insn", rvfi_insn, 32'd0);
        check("rst_rd_wdata", rvfi_rd_wdata, 32'd0);
        check("rst_ready", ret_ready, 1'b1);

        // Three back-to-back ADDs.
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("add_valid", rvfi_valid, 1'b1);
            check("add_order", rvfi_order, 64'(i));
            check("add_trap", rvfi_trap, 1'b0);
            check("add_rd_wdata", rvfi_rd_wdata, 32'd5);
        end
        check("add_pc_rdata", rvfi_pc_rdata, 32'h100);
        check("add_pc_wdata", rvfi_pc_wdata, 32'h104);
        ret_valid = 1'b0;
        step();
        check("idle_valid", rvfi_valid, 1'b0);
        check("idle_hold_insn", rvfi_insn, ADD);

        // Illegal all-zero instruction, then the handler-entry record.
        set_rec(32'h0, 5'd5, 32'hDEAD, 4'hF, 1'b0, 1'b0);
        step();
        check("ill_order", rvfi_order, 64'd3);
        check("ill_trap", rvfi_trap, 1'b1);
        check("ill_rd_addr", rvfi_rd_addr, 5'd0);
        check("ill_rd_wdata", rvfi_rd_wdata, 32'd0);
        check("ill_wmask", rvfi_mem_wmask, 4'h0);
        check("ill_rmask", rvfi_mem_rmask, 4'h0);
        check("ill_mem_wdata", rvfi_mem_wdata, 32'h0000_BEEF);
        check("ill_intr", rvfi_intr, 1'b0);
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        step();
        check("post_trap_intr", rvfi_intr, 1'b1);
        check("post_trap_order", rvfi_order, 64'd4);
        check("post_trap_trap", rvfi_trap, 1'b0);
        step();
        check("second_after_intr", rvfi_intr, 1'b0);
        check("second_after_order", rvfi_order, 64'd5);

        // Write to x0 reports zero data.
        set_rec(ADD, 5'd0, 32'h1234, 4'h0, 1'b0, 1'b0);
        step();
        check("x0_rd_wdata", rvfi_rd_wdata, 32'd0);
        check("x0_order", rvfi_order, 64'd6);

        // Halt record, then the tracer stays stopped.
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b1);
        step();
        check("halt_valid", rvfi_valid, 1'b1);
        check("halt_flag", rvfi_halt, 1'b1);
        check("halt_order", rvfi_order, 64'd7);
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("halted_ready", ret_ready, 1'b0);
            step();
            check("halted_valid", rvfi_valid, 1'b0);
        end

        // Order wrap on the 4-bit instance: 15, 0, 1.
        do_reset();
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step();
            if (i >= 15) begin
                check("wrap_valid", d4_valid, 1'b1);
                check("wrap_order", d4_order, 64'(i % 16));
            end
        end
        check("wide_no_wrap", rvfi_order, 64'd17);

        // Reset mid-stream with a record on the inputs.
        do_reset();
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_order", rvfi_order, 64'd3);
        reset = 1'b1;
        step();
        check("rst_cycle_valid", rvfi_valid, 1'b0);
        check("rst_cycle_order", rvfi_order, 64'd0);
        reset = 1'b0;
        // Legal instruction with a core trap: rd and write mask are cleared,
        // the read mask is kept.
        set_rec(ADD, 5'd3, 32'd5, 4'h3, 1'b1, 1'b0);
        step();
        check("post_rst_valid", rvfi_valid, 1'b1);
        check("post_rst_order", rvfi_order, 64'd0);
        check("post_rst_intr", rvfi_intr, 1'b0);
        check("core_trap_trap", rvfi_trap, 1'b1);
        check("core_trap_rd", rvfi_rd_addr, 5'd0);
        check("core_trap_wmask", rvfi_mem_wmask, 4'h0);
        check("core_trap_rmask", rvfi_mem_rmask, 4'hF);
        // Low opcode bits not 2'b11: illegal, and it is itself the intr record.
        set_rec(32'h0020_81B1, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        step();
        check("lowbits_trap", rvfi_trap, 1'b1);
        check("lowbits_intr", rvfi_intr, 1'b1);
        check("lowbits_order", rvfi_order, 64'd1);
        set_rec(ADD, 5'd3, 32'd5, 4'h0, 1'b0, 1'b0);
        step();
        check("rearm_intr", rvfi_intr, 1'b1);
        check("rearm_rd_wdata", rvfi_rd_wdata, 32'd5);
        ret_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rvfi_retire_tracer.md
Name: rvfi_retire_tracer

Overview:
- Producer end of the RVFI trace interface, for a single channel (NRET=1).
- Takes one retirement record per cycle from the core's writeback stage over a valid/ready handshake and registers it onto the rvfi_* outputs.
- Maintains rvfi_order, flags the first instruction after a trap as an interrupt/trap-handler entry (rvfi_intr), and sanitises illegal instructions so every rvfi_* consistency check holds by construction.
- Sits between the core writeback stage and the formal checker bank.

Parameters:
- XLEN, 32, register/address width.
- ILEN, 32, instruction width.
- ORDER_W, 64, width of rvfi_order counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- ret_valid  in  1  retirement record present.
- ret_ready  out  1  tracer accepts the record this cycle.
- ret_insn  in  ILEN  retired instruction word.
- ret_pc  in  XLEN  PC of the retired instruction.
- ret_next_pc  in  XLEN  next PC.
- ret_rs1_addr, ret_rs2_addr  in  5 each  source register indices.
- ret_rs1_rdata, ret_rs2_rdata  in  XLEN each  source register values.
- ret_rd_addr  in  5  destination register.
- ret_rd_wdata  in  XLEN  writeback value.
- ret_mem_addr, ret_mem_rdata, ret_mem_wdata  in  XLEN each  memory access fields.
- ret_mem_rmask, ret_mem_wmask  in  XLEN/8 each  byte masks.
- ret_trap  in  1  core signals trap on this instruction.
- ret_halt  in  1  last instruction before halt.
- rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr  out  1/ORDER_W/ILEN/1/1/1  standard RVFI.
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5 each  standard RVFI.
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata  out  XLEN each  standard RVFI.
- rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  out  XLEN each  standard RVFI.
- rvfi_mem_rmask, rvfi_mem_wmask  out  XLEN/8 each  standard RVFI.

Behaviour:
- Reset values: all rvfi_* outputs = 0, order counter = 0, intr_pending = 0, state = RUN.
- ret_ready = (state == RUN).
- Accept = ret_valid && ret_ready. Latency is exactly 1 cycle.
  - rvfi_valid is high in the cycle after an accept, and low otherwise.
  - Payload outputs hold their last value when rvfi_valid is low.
- rvfi_order:
  - Takes the counter value at accept; the counter then increments by 1.
  - Wraps modulo 2^ORDER_W.
  - The first retired instruction after reset has order 0.
- Illegal detection (combinational on ret_insn): illegal = (ret_insn == 0) || (ret_insn[1:0] != 2'b11).
- Sanitising rules on accept, in priority order:
  - If illegal: rvfi_trap = 1, rd_addr = 0, rd_wdata = 0, mem_wmask = 0, mem_rmask = 0. The remaining fields are copied unchanged.
  - Else: rvfi_trap = ret_trap. If ret_trap: rd_addr = 0, rd_wdata = 0, mem_wmask = 0.
  - Always: if the final rd_addr == 0, then rd_wdata = 0.
- rvfi_intr:
  - intr_pending is set on accept of any record whose final rvfi_trap = 1.
  - The next accepted record carries rvfi_intr = 1, and intr_pending clears on that accept.
  - A trapping record that is itself the intr record carries rvfi_intr = 1, and intr_pending re-sets.
- State machine:
  - RUN: on accept with ret_halt = 1, go to HALTED. That record carries rvfi_halt = 1.
  - HALTED: ret_ready = 0 and rvfi_valid = 0 on every cycle after the halt record. Only reset leaves HALTED.
- Reset mid-operation:
  - A record accepted in the cycle reset is asserted is discarded.
  - Outputs return to reset values on the next edge; the order counter restarts at 0.

Decomposition:
- Package rvfi_trace_pkg holds:
  - typedef rvfi_rec_t, a packed struct of all payload fields.
  - function is_illegal(insn).
  - localparam OPC_LOW_BITS = 2'b11.
  - enum tracer_state_e {RUN, HALTED}.
- One sub-module, rvfi_rec_sanitise: purely combinational, applying the illegal/trap/rd0 rules to an rvfi_rec_t. It is separately checkable.
- The top holds the order counter, intr_pending, the FSM and the output register.

Test Plan:
- Three back-to-back legal ADDs (insn 0x002081B3, rd=3, wdata=5) -> rvfi_valid on cycles 1,2,3; order 0,1,2; trap = 0.
- Accept ret_insn=0 with rd_addr=5, rd_wdata=0xDEAD, mem_wmask=0xF -> rvfi_trap=1, rd_addr=0, rd_wdata=0, mem_wmask=0; next legal record has rvfi_intr=1; the one after has rvfi_intr=0.
- Legal insn with rd_addr=0, rd_wdata=0x1234 -> rvfi_rd_wdata=0.
- Record with ret_halt=1 at order 7 -> rvfi_halt=1, order 7; ret_ready=0 and rvfi_valid=0 for 20 further cycles despite ret_valid=1.
- Preload counter to 2^ORDER_W-1 (ORDER_W=4 build) -> orders 15, 0, 1 in sequence.
- Assert reset while ret_valid=1, mid-stream after order 3 -> no rvfi_valid for the reset-cycle record; the first post-reset record has order 0 and intr=0.
